// File: rtl/swt16_pkg.sv
// swt16 shared definitions: default widths, PC step and the fetch-entry payload.
package swt16_pkg;

  localparam int unsigned DEF_WORD_WIDTH = 16;
  localparam int unsigned DEF_ADDR_WIDTH = 12;
  localparam int unsigned PC_INCR        = DEF_WORD_WIDTH / 8;

  // One fetched instruction together with the byte address it came from
  typedef struct packed {
    logic [DEF_WORD_WIDTH-1:0] instr;
    logic [DEF_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry FIFO of fetch entries; flush empties it, reset also clears storage.
module fetch_buf
  import swt16_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  entry_t     push_entry,
  input  logic       pop,
  input  logic       flush,
  output entry_t     head,
  output logic       empty,
  output logic [1:0] count
);

  entry_t     mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] cnt;

  // Storage, pointers and occupancy; flush drops contents without clearing them
  always_ff @(posedge clock) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == 2'd0);
  assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: swt16 instruction fetch. Issues byte addresses to program memory,
// captures the word one cycle later into a 2-entry buffer and presents it to
// decode over valid/ready. Redirects flush everything and restart at the target.
// Optional macro FETCH_STATS_EN adds transfer and stall counters.
module fetch_unit
  import swt16_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] out_pmem_addr,
  input  logic [WORD_WIDTH-1:0] in_pmem_word,
  input  logic                  in_redirect,
  input  logic [ADDR_WIDTH-1:0] in_redirect_pc,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic [WORD_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_instr_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]           out_fetch_cnt,
  output logic [15:0]           out_stall_cnt
`endif
);

  localparam int unsigned PC_STEP = WORD_WIDTH / 8;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight_valid;

  logic                  buf_empty;
  logic [1:0]            buf_count;
  entry_t                buf_head;

  logic                  pop_c;
  logic                  push_c;
  logic                  issue_c;
  logic [2:0]            level_c;
  logic [ADDR_WIDTH-1:0] target_c;
  entry_t                push_entry_c;

  // Handshake, capture and issue decisions; issue only if the buffer cannot overflow
  always_comb begin
    pop_c              = ~buf_empty & in_ready;
    push_c             = inflight_valid & ~in_redirect;
    level_c            = 3'(buf_count) + 3'(inflight_valid) - 3'(pop_c);
    issue_c            = ~in_redirect & (level_c < 3'd2);
    target_c           = in_redirect_pc & ~ADDR_WIDTH'(1);
    push_entry_c       = '0;
    push_entry_c.instr = in_pmem_word;
    push_entry_c.pc    = inflight_pc;
  end

  // Fetch PC and in-flight tracking; redirect outranks issue
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc       <= ADDR_WIDTH'(RESET_PC);
      inflight_pc    <= '0;
      inflight_valid <= 1'b0;
    end else if (in_redirect) begin
      fetch_pc       <= target_c;
      inflight_valid <= 1'b0;
    end else if (issue_c) begin
      fetch_pc       <= fetch_pc + ADDR_WIDTH'(PC_STEP);
      inflight_pc    <= fetch_pc;
      inflight_valid <= 1'b1;
    end else begin
      inflight_valid <= 1'b0;
    end
  end

  fetch_buf #(
    .entry_t (entry_t)
  ) u_buf (
    .clock      (clock),
    .reset      (reset),
    .push       (push_c),
    .push_entry (push_entry_c),
    .pop        (pop_c),
    .flush      (in_redirect),
    .head       (buf_head),
    .empty      (buf_empty),
    .count      (buf_count)
  );

  assign out_pmem_addr = fetch_pc;
  assign out_valid     = ~buf_empty;
  assign out_instr     = buf_head.instr;
  assign out_instr_pc  = buf_head.pc;

`ifdef FETCH_STATS_EN
  // Completed transfers and back-pressured cycles, both wrapping at 16 bits
  always_ff @(posedge clock) begin
    if (reset) begin
      out_fetch_cnt <= 16'd0;
      out_stall_cnt <= 16'd0;
    end else begin
      if (pop_c && !in_redirect) begin
        out_fetch_cnt <= out_fetch_cnt + 16'd1;
      end
      if (!buf_empty && !in_ready) begin
        out_stall_cnt <= out_stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized ready/redirect traffic,
// checked against a stream model (next expected pc, cycles since last restart).
module tb_fetch_unit;
  import swt16_pkg::*;

  localparam int unsigned AW     = DEF_ADDR_WIDTH;
  localparam int unsigned WW     = DEF_WORD_WIDTH;
  localparam int unsigned NWORDS = 1 << (AW - 1);

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] pmem_addr;
  logic [WW-1:0] pmem_word;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          valid;
  logic          ready;
  logic [WW-1:0] instr;
  logic [AW-1:0] instr_pc;
`ifdef FETCH_STATS_EN
  logic [15:0]   fetch_cnt;
  logic [15:0]   stall_cnt;
`endif

  logic [WW-1:0] mem [NWORDS];

  int            total  = 0;
  int            passed = 0;
  int            failed = 0;

  logic [AW-1:0] exp_pc;
  int            since;
  logic [15:0]   exp_fetch;
  logic [15:0]   exp_stall;

  always #5 clock = ~clock;

  // Program memory: word for the address sampled at the previous edge
  always @(posedge clock) pmem_word <= mem[pmem_addr[AW-1:1]];

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .out_pmem_addr  (pmem_addr),
    .in_pmem_word   (pmem_word),
    .in_redirect    (redirect),
    .in_redirect_pc (redirect_pc),
    .out_valid      (valid),
    .in_ready       (ready),
    .out_instr      (instr),
    .out_instr_pc   (instr_pc)
`ifdef FETCH_STATS_EN
    ,
    .out_fetch_cnt  (fetch_cnt),
    .out_stall_cnt  (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, then advance the model over the edge
  task automatic cycle();
    logic exp_valid;
    logic xfer;
    exp_valid = (since >= 2);
    chk("valid", 32'(valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("instr_pc", 32'(instr_pc), 32'(exp_pc));
      chk("instr", 32'(instr), 32'(mem[exp_pc[AW-1:1]]));
    end
`ifdef FETCH_STATS_EN
    chk("fetch_cnt", 32'(fetch_cnt), 32'(exp_fetch));
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif
    xfer = exp_valid && ready && !redirect && !reset;
    @(posedge clock);
    if (reset) begin
      exp_pc    = AW'(0);
      since     = 0;
      exp_fetch = 16'd0;
      exp_stall = 16'd0;
    end else begin
      if (exp_valid && !ready) exp_stall = exp_stall + 16'd1;
      if (xfer) exp_fetch = exp_fetch + 16'd1;
      if (redirect) begin
        exp_pc = {redirect_pc[AW-1:1], 1'b0};
        since  = 0;
      end else begin
        if (xfer) exp_pc = exp_pc + AW'(PC_INCR);
        if (since < 2) since++;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    logic [AW-1:0] wrap_seq [4];
    wrap_seq[0] = 12'hFFC;
    wrap_seq[1] = 12'hFFE;
    wrap_seq[2] = 12'h000;
    wrap_seq[3] = 12'h002;

    for (int i = 0; i < int'(NWORDS); i++) mem[i] = WW'(32'h1000 + i);
    reset       = 1'b1;
    ready       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    exp_pc      = '0;
    since       = 0;
    exp_fetch   = 16'd0;
    exp_stall   = 16'd0;

    // Reset state
    @(negedge clock);
    cycle();
    cycle();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_pmem_addr", 32'(pmem_addr), 32'd0);

    // First fetch: issue at E, push at E+1, valid afterwards
    reset = 1'b0;
    cycle();
    chk("pmem_addr_after_E", 32'(pmem_addr), 32'h002);
    cycle();
    chk("first_instr", 32'(instr), 32'h1000);
    chk("first_pc", 32'(instr_pc), 32'h000);
    repeat (3) cycle();

    // Stall with head 0x1003, then back-to-back release
    chk("stall_head", 32'(instr), 32'h1003);
    ready = 1'b0;
    repeat (5) begin
      chk("stall_hold", 32'(instr), 32'h1003);
      cycle();
    end
    ready = 1'b1;
    chk("release0", 32'(instr), 32'h1003);
    cycle();
    chk("release1", 32'(instr), 32'h1004);
    cycle();
    chk("release2_valid", 32'(valid), 32'd1);
    chk("release2", 32'(instr), 32'h1005);

    // Redirect to odd target 0x041 drops the pending transfer
    redirect    = 1'b1;
    redirect_pc = 12'h041;
    cycle();
    redirect = 1'b0;
    chk("redir_flush_valid", 32'(valid), 32'd0);
    cycle();
    cycle();
    chk("redir_pc", 32'(instr_pc), 32'h040);
    chk("redir_instr", 32'(instr), 32'h1020);
    repeat (2) cycle();

    // Address wrap
    redirect    = 1'b1;
    redirect_pc = 12'hFFC;
    cycle();
    redirect = 1'b0;
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      chk("wrap_pc", 32'(instr_pc), 32'(wrap_seq[i]));
      cycle();
    end

    // Reset while the buffer is full
    ready = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;
    ready = 1'b1;
    cycle();
    reset = 1'b0;
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_instr", 32'(instr), 32'd0);
    chk("midrst_pc", 32'(instr_pc), 32'd0);
    cycle();
    chk("midrst_E_valid", 32'(valid), 32'd0);
    cycle();
    chk("restart_pc", 32'(instr_pc), 32'h000);
    chk("restart_instr", 32'(instr), 32'h1000);

    // 10 transfers then 3 stalled cycles
    repeat (10) cycle();
    ready = 1'b0;
    repeat (3) cycle();
`ifdef FETCH_STATS_EN
    chk("stats_fetch10", 32'(fetch_cnt), 32'd10);
    chk("stats_stall3", 32'(stall_cnt), 32'd3);
`endif
    ready = 1'b1;

    // Randomized traffic over fresh memory contents
    reset = 1'b1;
    cycle();
    for (int i = 0; i < int'(NWORDS); i++) mem[i] = WW'($urandom);
    cycle();
`ifdef FETCH_STATS_EN
    chk("stats_reset_fetch", 32'(fetch_cnt), 32'd0);
    chk("stats_reset_stall", 32'(stall_cnt), 32'd0);
`endif
    reset = 1'b0;
    repeat (600) begin
      ready       = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = AW'($urandom);
      cycle();
    end
    redirect = 1'b0;
    ready    = 1'b1;
    repeat (4) cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the swt16 core. Drives the byte address into program memory, captures the returned word one cycle later, and hands instructions to decode over a valid/ready handshake. A 2-entry buffer absorbs the 1-cycle memory latency, so decode stalls never lose a fetched word. Branch redirects from execute flush all in-flight state and restart fetch at the target.

## Interface
- WORD_WIDTH, 16: instruction width in bits, always a multiple of 8.
- ADDR_WIDTH, 12: byte-address width.
- RESET_PC, 0: fetch address after reset.

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- out_pmem_addr  out  ADDR_WIDTH  byte address; program memory samples it on every rising edge.
- in_pmem_word  in  WORD_WIDTH  word for the address sampled at the previous edge; combinational from memory.
- in_redirect  in  1  flush pipeline and restart fetch.
- in_redirect_pc  in  ADDR_WIDTH  redirect target; bit 0 is forced to 0.
- out_valid  out  1  out_instr and out_instr_pc are valid.
- in_ready  in  1  decode accepts this cycle.
- out_instr  out  WORD_WIDTH  instruction at the buffer head.
- out_instr_pc  out  ADDR_WIDTH  byte address of out_instr.

## Operation
- State:
  - fetch_pc: registered, drives out_pmem_addr.
  - inflight_valid and inflight_pc: track the word memory is returning this cycle.
  - 2-entry FIFO of {instr, pc}: its head drives the outputs.
- Issue:
  - Occurs at an edge when reset=0, in_redirect=0 and (occupancy + inflight_valid − pop) < 2.
  - pop = out_valid & in_ready.
  - On issue: inflight_valid ← 1, inflight_pc ← fetch_pc, fetch_pc ← fetch_pc + WORD_WIDTH/8.
  - Otherwise: inflight_valid ← 0 and fetch_pc holds. Memory re-samples the same address, which is harmless.
- Capture: at each edge with inflight_valid=1 and no redirect, {in_pmem_word, inflight_pc} is pushed into the FIFO. The issue rule guarantees no overflow.
- Output:
  - out_valid = FIFO non-empty.
  - A transfer happens on an edge with out_valid & in_ready & ~in_redirect.
  - Outputs stay stable while out_valid=1 and in_ready=0.
- Redirect (priority over everything except reset):
  - FIFO emptied and inflight_valid ← 0.
  - fetch_pc ← {in_redirect_pc[ADDR_WIDTH-1:1], 1'b0}.
  - Any handshake in that cycle is discarded, not transferred.
- Arithmetic: fetch_pc wraps modulo 2^ADDR_WIDTH. Address 0xFFE is followed by 0x000 when ADDR_WIDTH=12.
- Reset values: fetch_pc=RESET_PC, FIFO empty, inflight_valid=0, out_valid=0, out_instr=0, out_instr_pc=0. A reset mid-stream discards everything, the same way a redirect does.

## Timing
- Let E be the first edge with reset=0. At E, memory samples RESET_PC and fetch issues it. At E+1 the word is pushed. out_valid=1 in the cycle after E+1.
- Issue-to-valid latency: 2 edges.
- Steady-state throughput: 1 instr/cycle with in_ready held at 1.
- Redirect penalty: in_redirect at edge R. The target is sampled at R+1, pushed at R+2, and out_valid rises after R+2.
- When in_ready drops:
  - The FIFO fills to 2: the current head plus the word in flight.
  - Issue stops one cycle later.
  - Re-assertion delivers the buffered words back-to-back with no bubble.

## Configuration
- FETCH_STATS_EN defined:
  - Adds output ports out_fetch_cnt[15:0] and out_stall_cnt[15:0]. Both reset to 0 and wrap at 0xFFFF.
  - out_fetch_cnt increments per completed transfer.
  - out_stall_cnt increments per cycle with out_valid=1 and in_ready=0.
- FETCH_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package swt16_pkg holds:
  - WORD_WIDTH and ADDR_WIDTH defaults;
  - PC_INCR = WORD_WIDTH/8;
  - the {instr, pc} fetch-entry typedef.
- Sub-module fetch_buf: 2-entry FIFO of fetch entries with push, pop, flush, empty and count.
- Issue logic, PC register, in-flight tracking and counters live in fetch_unit.

## Test plan
- Stream: pmem_sim model loaded with 0x1000+i at byte address 2i, in_ready=1 → from the cycle after E+1, out_instr = 0x1000, 0x1001, … and out_instr_pc = 0x000, 0x002, …, one per cycle.
- Stall: in_ready=0 for 5 cycles starting while head = 0x1003 → out_instr holds 0x1003. Release yields 0x1003, 0x1004 back-to-back, no duplicate, no skip.
- Redirect: in_redirect=1 with in_redirect_pc=0x041 while out_valid=1 → that transfer is dropped. After 2 edges, out_instr_pc=0x040 and out_instr = mem[0x20].
- Wrap: redirect to 0xFFC, in_ready=1 → out_instr_pc sequence is 0xFFC, 0xFFE, 0x000, 0x002.
- Reset mid-stream: reset=1 for 1 cycle while the FIFO is full → out_valid=0 the next cycle. Fetch restarts at RESET_PC with 2-edge latency.
- FETCH_STATS_EN: 10 transfers plus 3 stalled cycles → out_fetch_cnt=10, out_stall_cnt=3. Reset clears both to 0.
